// File: rtl/imem_loader.sv
// imem_loader: streams a length/data/checksum byte image into instruction memory and holds the CPU in reset until it verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_rst,
  output logic                  cpu_le,
  output logic                  load_done,
  output logic                  load_err,
  output logic [6:0]            words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
  state_t state, nxt;
  logic [9:0] cnt;
  logic [7:0] nwords, chk;
  logic acc, last, restart;
  assign acc = in_valid & in_ready;
  assign last = cnt == {nwords, 2'b00} - 10'd1;
  assign restart = start & (state inside {IDLE, DONE, ERR});
  always_comb begin
    nxt = state;
    case (state)
      LEN:     if (acc) nxt = in_data == 8'd0 ? CHK : int'(in_data) > MAX_WORDS ? ERR : DATA;
      DATA:    if (acc && last) nxt = CHK;
      CHK:     if (acc) nxt = in_data == chk ? DONE : ERR;
      default: if (start) nxt = LEN;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= ADDR_WIDTH'(BASE_ADDR);
      mem_data <= 8'd0;
      cpu_rst <= 1'b1;
      cpu_le <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      words_loaded <= 7'd0;
      cnt <= 10'd0;
      chk <= 8'd0;
      nwords <= 8'd0;
    end else begin
      state <= nxt;
      // status outputs track the state being entered so they change on the transition edge
      in_ready <= nxt inside {LEN, DATA, CHK};
      cpu_rst <= nxt != DONE;
      cpu_le <= nxt == DONE;
      load_done <= nxt == DONE;
      load_err <= nxt == ERR;
      mem_we <= state == DATA && acc;
      if (state == LEN && acc) nwords <= in_data;
      if (state == DATA && acc) begin
        mem_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt);
        mem_data <= in_data;
        cnt <= cnt + 10'd1;
        chk <= chk ^ in_data;
        if (cnt[1:0] == 2'd3) words_loaded <= words_loaded + 7'd1;
      end
      if (restart) begin
        cnt <= 10'd0;
        chk <= 8'd0;
        words_loaded <= 7'd0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random byte-stream loads checked against a stream-level model of the loader.
module tb_imem_loader;
  localparam int AW = 8;
  localparam int MW = 64;
  localparam int BA = 0;
  logic Clk = 0, Rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, mem_we, cpu_rst, cpu_le, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  logic [6:0] words_loaded;
  int checks = 0, errors = 0;
  logic [15:0] wq[$];

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .BASE_ADDR(BA)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_rst(cpu_rst), .cpu_le(cpu_le), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 Clk = ~Clk;
  always @(negedge Clk) if (mem_we) wq.push_back({mem_addr, mem_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1;
    in_data = b;
    @(negedge Clk);
    while (!in_ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    check("handshake_timeout", 32'(t < 20), 1);
    @(posedge Clk);
    #1 in_valid = 0;
  endtask

  // Expected outcome comes from the stream rules: length byte, 4N data bytes at consecutive addresses, XOR checksum.
  task automatic run_load(input logic [7:0] s[$], input bit gaps);
    int n, nb, nsend;
    logic [7:0] x;
    bit lenerr, ok;
    n = int'(s[0]);
    lenerr = n > MW;
    nb = lenerr ? 0 : 4 * n;
    nsend = lenerr ? 1 : nb + 2;
    x = 0;
    for (int i = 0; i < nb; i++) x ^= s[1 + i];
    ok = !lenerr && x == s[nb + 1];
    wq.delete();
    start = 1;
    @(posedge Clk);
    #1 start = 0;
    check("ready_after_start", 32'(in_ready), 1);
    check("err_cleared", 32'(load_err), 0);
    check("done_cleared", 32'(load_done), 0);
    check("cpu_rst_loading", 32'(cpu_rst), 1);
    for (int i = 0; i < nsend; i++) begin
      if (gaps && i > 0) begin
        @(posedge Clk);
        #1;
      end
      send(s[i]);
    end
    @(negedge Clk);
    check("load_done", 32'(load_done), 32'(ok));
    check("load_err", 32'(load_err), 32'(!ok));
    check("cpu_rst", 32'(cpu_rst), 32'(!ok));
    check("cpu_le", 32'(cpu_le), 32'(ok));
    check("words_loaded", 32'(words_loaded), lenerr ? 0 : 32'(n));
    check("ready_idle", 32'(in_ready), 0);
    check("write_count", 32'(wq.size()), 32'(nb));
    for (int i = 0; i < nb && i < wq.size(); i++)
      check("write", 32'(wq[i]), 32'({8'(BA + i), s[1 + i]}));
  endtask

  function automatic void gen(output logic [7:0] s[$], input int n, input bit bad);
    logic [7:0] x = 0;
    s = {};
    s.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      s.push_back(8'($urandom));
      x ^= s[$];
    end
    s.push_back(bad ? x ^ 8'($urandom_range(1, 255)) : x);
  endfunction

  initial begin
    logic [7:0] s[$];
    repeat (2) @(posedge Clk);
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_cpu_le", 32'(cpu_le), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_addr", 32'(mem_addr), BA);
    Rst = 0;
    s = '{8'h02, 8'h08, 8'h00, 8'h06, 8'h18, 8'h34, 8'h22, 8'h00, 8'h0A, 8'h0A};
    run_load(s, 0);
    run_load(s, 1);
    s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    run_load(s, 0);
    s = '{8'd65};
    run_load(s, 0);
    s = '{8'h00, 8'h00};
    run_load(s, 0);
    s = '{8'h00, 8'h5A};
    run_load(s, 1);
    gen(s, MW, 0);
    run_load(s, 0);
    // reset in the middle of the data phase
    gen(s, 2, 0);
    wq.delete();
    start = 1;
    @(posedge Clk);
    #1 start = 0;
    for (int i = 0; i < 4; i++) send(s[i]);
    Rst = 1;
    @(posedge Clk);
    #1 Rst = 0;
    check("midrst_mem_we", 32'(mem_we), 0);
    check("midrst_ready", 32'(in_ready), 0);
    check("midrst_words", 32'(words_loaded), 0);
    check("midrst_cpu_rst", 32'(cpu_rst), 1);
    check("midrst_writes", 32'(wq.size()), 3);
    run_load(s, 0);
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        s = {};
        s.push_back(8'($urandom_range(MW + 1, 255)));
      end else gen(s, $urandom_range(0, 8), $urandom_range(0, 3) == 0);
      run_load(s, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
